// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// Waits for the pixel PLL to report lock, lets the clock settle for SETTLE
// cycles, then free-runs the horizontal/vertical counters and derives the
// sync, display-enable and position outputs from them. Any loss of lock
// drops the generator back to IDLE; a new lock always starts a fresh frame
// at pixel (0,0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SETTLE   = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    // Frame geometry, all in 10-bit counter space.
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HT_LAST     = 10'(HT - 1);
    localparam logic [9:0] VT_LAST     = 10'(VT - 1);
    localparam logic [9:0] H_VIS_END   = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END      = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Settle counter only needs to reach SETTLE-1.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [SW-1:0] settle_cnt_r;
    logic [9:0]    hcnt_r;
    logic [9:0]    vcnt_r;

    logic          locked_meta_r;
    logic          locked_sync_r;
    logic          locked_s;

    logic          in_run_s;
    logic          de_nxt_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;
    logic [9:0]    x_nxt_s;
    logic [9:0]    y_nxt_s;
    logic          line_start_nxt_s;
    logic          frame_start_nxt_s;

    logic          hsync_r;
    logic          vsync_r;
    logic          de_r;
    logic [9:0]    x_r;
    logic [9:0]    y_r;
    logic          line_start_r;
    logic          frame_start_r;
    logic          running_r;

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta_r <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            locked_meta_r <= locked;
            locked_sync_r <= locked_meta_r;
        end
    end

    assign locked_s = locked_sync_r;

    // Lock/settle FSM together with the raster counters it gates.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            settle_cnt_r <= '0;
            hcnt_r       <= 10'd0;
            vcnt_r       <= 10'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    hcnt_r       <= 10'd0;
                    vcnt_r       <= 10'd0;
                    settle_cnt_r <= '0;
                    if (locked_s) begin
                        state_r <= ARM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARM: begin
                    hcnt_r <= 10'd0;
                    vcnt_r <= 10'd0;
                    if (!locked_s) begin
                        state_r      <= IDLE;
                        settle_cnt_r <= '0;
                    end else if (settle_cnt_r == SETTLE_LAST) begin
                        state_r      <= RUN;
                        settle_cnt_r <= '0;
                    end else begin
                        state_r      <= ARM;
                        settle_cnt_r <= settle_cnt_r + SW'(1);
                    end
                end
                RUN: begin
                    settle_cnt_r <= '0;
                    if (!locked_s) begin
                        // Lost lock: abandon the frame, never resume it.
                        state_r <= IDLE;
                        hcnt_r  <= 10'd0;
                        vcnt_r  <= 10'd0;
                    end else begin
                        state_r <= RUN;
                        if (hcnt_r == HT_LAST) begin
                            hcnt_r <= 10'd0;
                            if (vcnt_r == VT_LAST) begin
                                vcnt_r <= 10'd0;
                            end else begin
                                vcnt_r <= vcnt_r + 10'd1;
                            end
                        end else begin
                            hcnt_r <= hcnt_r + 10'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    settle_cnt_r <= '0;
                    hcnt_r       <= 10'd0;
                    vcnt_r       <= 10'd0;
                end
            endcase
        end
    end

    // Decode the next output values from the current state and counters.
    always_comb begin
        in_run_s          = (state_r == RUN);
        de_nxt_s          = in_run_s && (hcnt_r < H_VIS_END) && (vcnt_r < V_VIS_END);
        hsync_nxt_s       = !(in_run_s && (hcnt_r >= HS_START) && (hcnt_r < HS_END));
        vsync_nxt_s       = !(in_run_s && (vcnt_r >= VS_START) && (vcnt_r < VS_END));
        x_nxt_s           = in_run_s ? hcnt_r : 10'd0;
        y_nxt_s           = in_run_s ? vcnt_r : 10'd0;
        line_start_nxt_s  = in_run_s && (hcnt_r == 10'd0);
        frame_start_nxt_s = line_start_nxt_s && (vcnt_r == 10'd0);
    end

    // Output register stage: every output lags the counters by one cycle.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            de_r          <= 1'b0;
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            running_r     <= 1'b0;
        end else begin
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            de_r          <= de_nxt_s;
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            line_start_r  <= line_start_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            running_r     <= in_run_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign x           = x_r;
    assign y           = y_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign running     = running_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster so whole frames
// fit in a short run: HT = 16+4+6+4 = 30, VT = 8+2+2+3 = 15, frame = 450.
module tb_vga_timing_gen;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic       running;

    int n_cmp = 0;
    int n_mis = 0;

    vga_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (4),
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .SETTLE   (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
    );

    // Pixel clock.
    initial refclk = 1'b0;
    always #20 refclk = ~refclk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // {hsync, vsync, de, line_start, frame_start, running}
    function automatic logic [5:0] status();
        return {hsync, vsync, de, line_start, frame_start, running};
    endfunction

    // Stimulus and checks.
    initial begin
        int de_cnt;
        int de_line0;
        int ls_cnt;
        int hs_cnt;
        int vs_cnt;
        int fs_cnt;
        int hs_fall;
        int ls_second;
        int vs_fall_c;
        int vs_fall_x;
        int vs_fall_y;
        int early;
        int waited;
        logic prev_hs;
        logic prev_vs;

        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) tick();
        check_eq("reset_status", 32'(status()), 32'(6'b110000));
        check_eq("reset_x", 32'(x), 32'd0);
        check_eq("reset_y", 32'(y), 32'd0);

        // Lock held high through reset release; next edge is N.
        locked = 1'b1;
        tick();
        rst = 1'b0;
        early = 0;
        for (int i = 0; i <= 18; i++) begin
            tick();                       // edges N .. N+18
            if (running || frame_start || de) early++;
        end
        check_eq("no_output_before_n19", 32'(early), 32'd0);
        tick();                           // edge N+19
        check_eq("first_frame_status", 32'(status()), 32'(6'b111111));
        check_eq("first_frame_x", 32'(x), 32'd0);
        check_eq("first_frame_y", 32'(y), 32'd0);

        // Measure one complete frame.
        de_cnt = 0; de_line0 = 0; ls_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        hs_fall = -1; ls_second = -1; vs_fall_c = -1; vs_fall_x = -1; vs_fall_y = -1;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        for (int c = 0; c < 450; c++) begin
            if (de) de_cnt++;
            if (de && c < 30) de_line0++;
            if (line_start) ls_cnt++;
            if (!hsync) hs_cnt++;
            if (!vsync) vs_cnt++;
            if (frame_start) fs_cnt++;
            if (prev_hs && !hsync && hs_fall < 0) hs_fall = c;
            if (line_start && c > 0 && ls_second < 0) ls_second = c;
            if (prev_vs && !vsync && vs_fall_c < 0) begin
                vs_fall_c = c;
                vs_fall_x = int'(x);
                vs_fall_y = int'(y);
            end
            prev_hs = hsync;
            prev_vs = vsync;
            tick();
        end
        check_eq("de_per_frame", 32'(de_cnt), 32'd128);
        check_eq("de_first_line", 32'(de_line0), 32'd16);
        check_eq("lines_per_frame", 32'(ls_cnt), 32'd15);
        check_eq("line_period", 32'(ls_second), 32'd30);
        check_eq("hsync_fall_offset", 32'(hs_fall), 32'd20);
        check_eq("hsync_low_cycles", 32'(hs_cnt), 32'd90);
        check_eq("vsync_low_cycles", 32'(vs_cnt), 32'd60);
        check_eq("vsync_fall_cycle", 32'(vs_fall_c), 32'd300);
        check_eq("vsync_fall_x", 32'(vs_fall_x), 32'd0);
        check_eq("vsync_fall_y", 32'(vs_fall_y), 32'd10);
        check_eq("frame_starts_per_frame", 32'(fs_cnt), 32'd1);
        check_eq("second_frame_start", 32'({frame_start, line_start}), 32'(2'b11));

        // Drop lock mid-frame at (12,5).
        waited = 0;
        while (!(x == 10'd12 && y == 10'd5) && waited < 1000) begin
            tick();
            waited++;
        end
        check_eq("wait_pixel_12_5", 32'(waited < 1000), 32'd1);
        locked = 1'b0;
        repeat (3) tick();
        check_eq("still_running_after_3", 32'(running), 32'd1);
        check_eq("x_after_3", 32'(x), 32'd15);
        tick();
        check_eq("drop_status", 32'(status()), 32'(6'b110000));
        check_eq("drop_xy", 32'({x, y}), 32'd0);

        // Relock with a one-cycle glitch while settle_cnt sits at 10.
        repeat (5) tick();
        locked = 1'b1;
        early = 0;
        for (int i = 0; i <= 10; i++) begin
            tick();                       // edges A .. A+10
            if (running || frame_start) early++;
        end
        locked = 1'b0;
        tick();                           // edge A+11 samples the glitch
        locked = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();                       // edges A+12 .. A+30
            if (running || frame_start) early++;
        end
        check_eq("no_early_frame_after_glitch", 32'(early), 32'd0);
        tick();                           // edge A+31
        check_eq("relock_status", 32'(status()), 32'(6'b111111));
        check_eq("relock_xy", 32'({x, y}), 32'd0);

        // Asynchronous reset between edges.
        repeat (50) tick();
        check_eq("running_before_rst", 32'({running, x}), 32'({1'b1, 10'd20}));
        @(posedge refclk);
        #13;
        rst = 1'b1;
        #1;
        check_eq("async_rst_status", 32'(status()), 32'(6'b110000));
        check_eq("async_rst_xy", 32'({x, y}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
